led_indicator_bank: RTL and testbench
=====================================

# led_indicator_bank

Parametrised multi-channel LED indicator driving the on-board LEDs from one system clock. It generalises the single-channel heartbeat counter to NUM_CH channels. Each channel runs in one of four modes: off, on, blink, breathe (PWM). Each channel also has a pulse-stretch input that holds the LED on long enough for a short event, such as an interrupt acknowledge, to be seen. It sits in the top-level wrapper between the processor-side status/GPIO signals and the board LED pins.

## Interface
- CLK_FREQ, 100_000_000: clk frequency in Hz.
- TICK_HZ, 1000: internal tick rate (1 ms tick). DIV = CLK_FREQ/TICK_HZ, must be ≥ 2 (elaboration assertion).
- NUM_CH, 8: number of LED channels, 1..32.
- PWM_BITS, 8: breathe PWM resolution.
- STRETCH_TICKS, 50: pulse-stretch length in ticks.
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  global enable; low blanks all LEDs.
- mode  in  NUM_CH×2 (packed [NUM_CH-1:0][1:0])  per-channel mode, led_mode_e.
- blink_half  in  16  blink half-period in ticks; 0 is treated as 1.
- pulse  in  NUM_CH  per-channel event inputs, synchronous to clk.
- led  out  NUM_CH  registered LED drive, active-high.
- tick  out  1  one-cycle tick strobe, for debug/chaining.

## Operation
- Prescaler: cnt runs 0..DIV-1, then wraps. tick=1 for the single cycle in which cnt==DIV-1.
- Blink generator, shared by all channels so that blinking channels stay phase-aligned:
  - bcnt advances on tick.
  - When tick arrives with bcnt ≥ max(blink_half,1)-1: bcnt←0 and blink_phase toggles.
  - The ≥ compare makes a runtime shrink of blink_half wrap on the next tick, never run away.
- Breathe generator, shared:
  - pwm_cnt is PWM_BITS wide and free-runs every clk.
  - duty steps ±1 per tick as a triangle: 0→2^PWM_BITS-1, then back to 0, then up again. dir flips on reaching either end.
  - breathe_out = (pwm_cnt < duty).
- Per-channel base value by mode: OFF=0, ON=1, BLINK=blink_phase, BREATHE=breathe_out.
- Pulse stretch, per channel:
  - Rising-edge detect on pulse[i] against a registered copy.
  - On an edge, scnt[i]←STRETCH_TICKS. A retrigger while active reloads.
  - Otherwise scnt[i] decrements on tick while nonzero.
  - Edge and tick in the same cycle: load wins.
  - led[i] = enable & (base[i] | (scnt[i]!=0)). Stretch overrides every mode, including OFF.
- enable low:
  - led=0.
  - All scnt cleared; edges are ignored.
  - Prescaler, bcnt, blink_phase, duty and dir freeze; pwm_cnt keeps running.
  - Re-enable resumes from the frozen state.
- A mode change takes effect on the next led update. No glitch beyond one clk.

## Timing
- Reset values: led=0, tick=0, cnt=0, bcnt=0, blink_phase=0, pwm_cnt=0, duty=0, dir=up, scnt=0, pulse edge register=0.
- A pulse held high through reset release does not trigger: the edge register samples pulse from the first clk after reset.
- The led register updates every clk from current state. Latency is 1 clk from mode/enable change to led.
- A pulse edge in cycle n gives led[i]=1 at n+2 (edge register, then output register).
- The stretch lasts STRETCH_TICKS full ticks ±1 tick, depending on prescaler phase.
- Blink period = 2·max(blink_half,1)·DIV clk.
- Breathe period = 2·(2^PWM_BITS-1) ticks.
- Asserting rst_n low mid-operation forces all outputs to reset values immediately (async).

## Structure
- Package led_ind_pkg:
  - typedef enum logic [1:0] led_mode_e {LED_OFF, LED_ON, LED_BLINK, LED_BREATHE}.
  - Localparam helper for DIV width ($clog2).
- Sub-module led_tick_gen: the prescaler. Parameter DIV, ports clk, rst_n, enable, tick.
- Blink, breathe and per-channel stretch logic live in led_indicator_bank (generate loop over channels).

## Test plan
Bench parameters unless stated: CLK_FREQ=1000, TICK_HZ=100 (DIV=10), NUM_CH=4, PWM_BITS=3, STRETCH_TICKS=5.
- Reset / tick:
  - Stimulus: hold rst_n low for 3 clk, release.
  - Required: all outputs 0 during reset; first tick at clk 10 after release; then every 10 clk.
- ON/OFF and enable:
  - Stimulus: mode={ON,OFF,ON,OFF}; then enable=0 for 20 clk.
  - Required: led=4'b0101 one clk after setting; led=0 while disabled; 4'b0101 again one clk after re-enable.
- Blink:
  - Stimulus: blink_half=3, ch0=BLINK; then change blink_half 3→1 mid-count; then blink_half=0.
  - Required: led[0] toggles every 30 clk; after the change, it toggles on the next tick; blink_half=0 gives toggling every 10 clk.
- Breathe:
  - Stimulus: ch1=BREATHE.
  - Required: duty ramps 0..7..0 over 14 ticks; high count per 8-clk PWM window equals duty.
- Pulse stretch:
  - Stimulus: ch2=OFF, 1-clk pulse[2].
  - Required: led[2] high from edge+2 clk for 5 ticks (±1 tick).
  - Stimulus: retrigger at tick 3.
  - Required: high extends to 5 ticks after the retrigger.
  - Stimulus: edge coincident with tick.
  - Required: counter reloads to 5.
- Pulse during reset:
  - Stimulus: pulse[3] high across rst_n release.
  - Required: no stretch. A later 0→1 edge does stretch.

Source files
------------

// File: rtl/led_ind_pkg.sv
// Shared types and helpers for the LED indicator bank.
// Mode encoding and counter-width helper.
package led_ind_pkg;

  typedef enum logic [1:0] {
    LED_OFF,
    LED_ON,
    LED_BLINK,
    LED_BREATHE
  } led_mode_e;

  localparam int BLINK_W = 16;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler producing a one-cycle tick every DIV clocks.
// Frozen while enable is low.
module led_tick_gen
  import led_ind_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int W = cnt_w(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  if (DIV < 2) begin : g_div_chk
    $error("led_tick_gen: DIV must be at least 2");
  end

  // Wrap counter 0..DIV-1, held while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

  assign tick = enable & (cnt == LAST);

endmodule

// File: rtl/led_indicator_bank.sv
// Multi-channel LED driver: off/on/blink/breathe modes
// with per-channel pulse stretching.
module led_indicator_bank
  import led_ind_pkg::*;
#(
  parameter int CLK_FREQ      = 100_000_000,
  parameter int TICK_HZ       = 1000,
  parameter int NUM_CH        = 8,
  parameter int PWM_BITS      = 8,
  parameter int STRETCH_TICKS = 50
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [NUM_CH-1:0][1:0] mode,
  input  logic [15:0]            blink_half,
  input  logic [NUM_CH-1:0]      pulse,
  output logic [NUM_CH-1:0]      led,
  output logic                   tick
);

  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int SW  = cnt_w(STRETCH_TICKS + 1);

  localparam logic [SW-1:0] S_LOAD =
    SW'(STRETCH_TICKS);
  localparam logic [PWM_BITS-1:0] D_MAX = '1;
  localparam logic [PWM_BITS-1:0] D_TOP =
    D_MAX - PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] D_ONE =
    PWM_BITS'(1);

  logic [BLINK_W-1:0]  bcnt;
  logic [BLINK_W-1:0]  bh_last;
  logic                blink_phase;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty;
  logic                dir_up;
  logic                breathe_out;
  logic                armed;
  logic [NUM_CH-1:0]   pulse_q;
  logic [NUM_CH-1:0]   edge_det;
  logic [NUM_CH-1:0]   led_next;

  led_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .tick   (tick)
  );

  assign bh_last = (blink_half == '0) ? '0
                 : blink_half - BLINK_W'(1);

  // Shared blink phase; >= compare tolerates shrinking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt        <= '0;
      blink_phase <= 1'b0;
    end else if (tick) begin
      if (bcnt >= bh_last) begin
        bcnt        <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        bcnt <= bcnt + BLINK_W'(1);
      end
    end
  end

  // Free-running PWM carrier
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // Triangle duty ramp, one step per tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty   <= '0;
      dir_up <= 1'b1;
    end else if (tick) begin
      if (dir_up) begin
        duty <= duty + PWM_BITS'(1);
        if (duty == D_TOP) dir_up <= 1'b0;
      end else begin
        duty <= duty - PWM_BITS'(1);
        if (duty == D_ONE) dir_up <= 1'b1;
      end
    end
  end

  assign breathe_out = (pwm_cnt < duty);

  // Blocks edges until pulse has been sampled once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed   <= 1'b0;
      pulse_q <= '0;
    end else begin
      armed   <= 1'b1;
      pulse_q <= pulse;
    end
  end

  assign edge_det = pulse & ~pulse_q
                  & {NUM_CH{armed}};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic          base;
    logic [SW-1:0] scnt;

    // Mode select for this channel
    always_comb begin
      base = 1'b0;
      unique case (led_mode_e'(mode[i]))
        LED_OFF:     base = 1'b0;
        LED_ON:      base = 1'b1;
        LED_BLINK:   base = blink_phase;
        LED_BREATHE: base = breathe_out;
      endcase
    end

    // Stretch counter; a fresh edge beats a tick
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        scnt <= '0;
      end else if (!enable) begin
        scnt <= '0;
      end else if (edge_det[i]) begin
        scnt <= S_LOAD;
      end else if (tick && scnt != '0) begin
        scnt <= scnt - SW'(1);
      end
    end

    assign led_next[i] =
      enable & (base | (scnt != '0));
  end

  // Registered LED drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= '0;
    end else begin
      led <= led_next;
    end
  end

endmodule

// File: tb/tb_led_indicator_bank.sv
// Randomized bench for led_indicator_bank with a
// tick-count based reference model.
module tb_led_indicator_bank;

  localparam int CLK_FREQ = 1000;
  localparam int TICK_HZ  = 100;
  localparam int DIV      = CLK_FREQ / TICK_HZ;
  localparam int NCH      = 4;
  localparam int PWB      = 3;
  localparam int STR      = 5;
  localparam int DMAX     = (1 << PWB) - 1;

  logic                clk;
  logic                rst_n;
  logic                enable;
  logic [NCH-1:0][1:0] mode;
  logic [15:0]         blink_half;
  logic [NCH-1:0]      pulse;
  logic [NCH-1:0]      led;
  logic                tick;

  int n_chk;
  int n_err;

  // reference model state
  int unsigned en_cyc;
  int unsigned nticks;
  int unsigned btk;
  int unsigned pwm;
  bit          phase;
  int          sc [NCH];
  bit          pprev [NCH];
  bit          armed_m;
  logic [NCH-1:0] led_exp;

  led_indicator_bank #(
    .CLK_FREQ      (CLK_FREQ),
    .TICK_HZ       (TICK_HZ),
    .NUM_CH        (NCH),
    .PWM_BITS      (PWB),
    .STRETCH_TICKS (STR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .mode       (mode),
    .blink_half (blink_half),
    .pulse      (pulse),
    .led        (led),
    .tick       (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  function automatic int tri_duty(input int unsigned t);
    int p;
    p = int'(t % (2 * DMAX));
    return (p <= DMAX) ? p : 2 * DMAX - p;
  endfunction

  task automatic model_reset();
    en_cyc  = 0;
    nticks  = 0;
    btk     = 0;
    pwm     = 0;
    phase   = 0;
    armed_m = 0;
    led_exp = '0;
    for (int i = 0; i < NCH; i++) begin
      sc[i]    = 0;
      pprev[i] = 0;
    end
  endtask

  function automatic bit tick_now();
    return rst_n && enable
        && (en_cyc % DIV == DIV - 1);
  endfunction

  // one clock of the reference behaviour
  task automatic model_step();
    bit tk;
    bit b;
    bit e;
    int d;
    int bhe;
    tk = tick_now();
    d  = tri_duty(nticks);
    for (int i = 0; i < NCH; i++) begin
      case (mode[i])
        2'd0: b = 0;
        2'd1: b = 1;
        2'd2: b = phase;
        default: b = int'(pwm % (DMAX + 1)) < d;
      endcase
      led_exp[i] = enable && (b || sc[i] != 0);
    end
    for (int i = 0; i < NCH; i++) begin
      e = armed_m && pulse[i] && !pprev[i];
      if (!enable) sc[i] = 0;
      else if (e) sc[i] = STR;
      else if (tk && sc[i] > 0) sc[i]--;
      pprev[i] = pulse[i];
    end
    if (tk) begin
      bhe = (blink_half == 0) ? 1 : int'(blink_half);
      if (int'(btk) >= bhe - 1) begin
        btk   = 0;
        phase = ~phase;
      end else begin
        btk++;
      end
      nticks++;
    end
    if (enable) en_cyc++;
    pwm++;
    armed_m = 1;
  endtask

  // advance one clock, then compare at the negedge
  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    @(negedge clk);
    chk("led", led, led_exp);
    chk("tick", tick, tick_now());
  endtask

  task automatic cycn(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  // measure how many cycles led[ch] stays high
  task automatic high_len(input int ch,
                          output int len);
    int k;
    len = 0;
    k   = 0;
    while (led[ch] && k < 200) begin
      len++;
      k++;
      cyc();
    end
    if (k >= 200) chk("len_timeout", 1, 0);
  endtask

  int k;
  int first;
  int gap;
  int len;
  int togg;
  logic prev;

  initial begin
    n_chk      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    enable     = 1'b0;
    mode       = '0;
    blink_half = 16'd3;
    pulse      = '0;
    model_reset();

    cycn(3);
    chk("rst_led", led, 0);
    chk("rst_tick", tick, 0);

    // release with pulse[3] held high
    pulse[3] = 1'b1;
    rst_n    = 1'b1;
    enable   = 1'b1;

    first = 0;
    k     = 0;
    while (!tick && k < 30) begin
      cyc();
      k++;
    end
    first = k + 1;
    chk("first_tick_clk", first, 10);
    gap = 0;
    cyc();
    while (!tick && gap < 30) begin
      cyc();
      gap++;
    end
    chk("tick_gap", gap + 1, 10);
    chk("rst_pulse_led3", led[3], 0);

    pulse[3] = 1'b0;
    cyc();
    pulse[3] = 1'b1;
    cycn(2);
    chk("late_edge_led3", led[3], 1);
    pulse[3] = 1'b0;
    cycn(60);
    chk("stretch_end_led3", led[3], 0);

    // ON/OFF and enable
    mode[0] = 2'd1;
    mode[1] = 2'd0;
    mode[2] = 2'd1;
    mode[3] = 2'd0;
    cyc();
    chk("onoff", led, 4'b0101);
    enable = 1'b0;
    cyc();
    chk("disabled", led, 0);
    cycn(19);
    chk("disabled_end", led, 0);
    enable = 1'b1;
    cyc();
    chk("reenable", led, 4'b0101);

    // blink with half=3: 4 toggles per 120 clk
    mode[0] = 2'd2;
    cycn(40);
    togg = 0;
    prev = led[0];
    for (int i = 0; i < 120; i++) begin
      cyc();
      if (led[0] != prev) togg++;
      prev = led[0];
    end
    chk("blink3_toggles", togg, 4);
    cycn(12);
    blink_half = 16'd1;
    cycn(30);
    blink_half = 16'd0;
    cycn(20);
    togg = 0;
    prev = led[0];
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (led[0] != prev) togg++;
      prev = led[0];
    end
    chk("blink0_toggles", togg, 10);

    // breathe over two full periods
    mode[1] = 2'd3;
    cycn(2 * 2 * DMAX * DIV);

    // single stretch on an OFF channel
    mode[2] = 2'd0;
    cycn(2);
    pulse[2] = 1'b1;
    cyc();
    pulse[2] = 1'b0;
    chk("stretch_edge1", led[2], 0);
    cyc();
    chk("stretch_edge2", led[2], 1);
    high_len(2, len);
    chk("stretch_len_ok",
        (len >= 40 && len <= 60), 1);

    // retrigger after three ticks
    pulse[2] = 1'b1;
    cyc();
    pulse[2] = 1'b0;
    k = 0;
    gap = 0;
    while (k < 3 && gap < 100) begin
      cyc();
      if (tick) k++;
      gap++;
    end
    pulse[2] = 1'b1;
    cyc();
    pulse[2] = 1'b0;
    cyc();
    high_len(2, len);
    chk("retrig_len_ok",
        (len >= 40 && len <= 60), 1);
    cycn(5);

    // edge coincident with tick
    k = 0;
    while (!tick && k < 30) begin
      cyc();
      k++;
    end
    chk("coinc_tick_seen", tick, 1);
    pulse[2] = 1'b1;
    cyc();
    pulse[2] = 1'b0;
    cyc();
    high_len(2, len);
    chk("coinc_len", len, 50);

    // randomized run
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 15) == 0)
        mode[$urandom_range(0, NCH - 1)] =
          2'($urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0)
        blink_half = 16'($urandom_range(0, 4));
      if ($urandom_range(0, 31) == 0)
        enable = ~enable;
      if ($urandom_range(0, 7) == 0)
        pulse[$urandom_range(0, NCH - 1)] ^= 1'b1;
      cyc();
    end

    // asynchronous reset mid-operation
    enable = 1'b1;
    mode   = {2'd1, 2'd1, 2'd1, 2'd1};
    cycn(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_led", led, 0);
    chk("async_tick", tick, 0);
    model_reset();
    cyc();
    pulse = '0;
    rst_n = 1'b1;
    cycn(40);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
